// File: rtl/pipe_div_recover_pkg.sv
// Shared types and constants for the pipe_div_recover restoring divider.
// The divider recovers x3 = f / d from a captured arithmetic-pipe result.
package pipe_div_recover_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_W   = 10;
  localparam int CNT_W = $clog2(N_W + 1);

endpackage

// File: rtl/pipe_div_recover_step.sv
// One combinational restoring-division step: shift {rem,quo} left by one,
// then subtract the divisor when it fits, setting the new quotient LSB.
module pipe_div_recover_step #(
  parameter int n = 10
) (
  input  logic [n:0]   rem,
  input  logic [n-1:0] quo,
  input  logic [n-1:0] divisor,
  output logic [n:0]   rem_nxt,
  output logic [n-1:0] quo_nxt
);

  logic [n+1:0] sh;
  logic [n:0]   diff;
  logic         ge;

  // Widened by one bit so the compare never overflows for divisor = 2^n-1.
  assign sh      = {rem, quo[n-1]};
  assign ge      = sh >= {2'b00, divisor};
  assign diff    = sh[n:0] - {1'b0, divisor};
  assign rem_nxt = ge ? diff : sh[n:0];
  assign quo_nxt = {quo[n-2:0], ge};

endmodule

// File: rtl/pipe_div_recover.sv
// Iterative unsigned restoring divider, q = f / d and r = f % d, one bit per
// clock, with valid/ready handshakes on both sides and one operation in flight.
module pipe_div_recover
  import pipe_div_recover_pkg::*;
#(
  parameter int n = N_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] f,
  input  logic [n-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] q,
  output logic [n-1:0] r,
  output logic         div_zero
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // the producer holds its data stable while valid is high and ready is low.
  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  state_t        state;
  state_t        state_nxt;
  logic [n:0]    rem;
  logic [n-1:0]  quo;
  logic [n-1:0]  divisor;
  logic [CW-1:0] count;
  logic [n:0]    rem_nxt;
  logic [n-1:0]  quo_nxt;
  logic          accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  pipe_div_recover_step #(.n(n)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (divisor),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (d == '0) ? DONE : CALC;
      CALC: if (count == LAST) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      count    <= '0;
      q        <= '0;
      r        <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            divisor <= d;
            quo     <= f;
            rem     <= '0;
            count   <= '0;
            // Divide-by-zero skips the iteration and reports an all-ones quotient.
            if (d == '0) begin
              q        <= '1;
              r        <= f;
              div_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          rem   <= rem_nxt;
          quo   <= quo_nxt;
          count <= count + 1'b1;
          if (count == LAST) begin
            q        <= quo_nxt;
            r        <= rem_nxt[n-1:0];
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pipe_div_recover.md
Name: pipe_div_recover

Overview:
- Inverse-direction companion to the 3-stage arithmetic pipe, which produces f = x3*d where x3 = (a+b)+(c-d).
- Takes a captured pipe result f and its d operand, then recovers x3 = f / d and the remainder with an iterative restoring divider.
- Sits on the checking/decode side of the pipe output.
- Valid/ready handshake on both input and output; one operation in flight.

Parameters:
- n, 10, operand/result width; matches the pipe datapath width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  f/d operands valid
- in_ready  output  1  block can accept operands
- f  input  n  dividend (pipe result)
- d  input  n  divisor (pipe d operand)
- out_valid  output  1  q/r/div_zero valid
- out_ready  input  1  consumer accepts result
- q  output  n  quotient (recovered x3)
- r  output  n  remainder
- div_zero  output  1  d was zero for this result

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; q, r, div_zero, out_valid=0; internal rem/quo/divisor/count=0.
  - in_ready=1 once rst_n deasserts.
  - Assertion mid-CALC or mid-DONE aborts the operation immediately; no result emitted.
- FSM states: IDLE, CALC, DONE.
- in_ready = (state==IDLE), combinational; out_valid = (state==DONE), registered via state.
- IDLE:
  - On clk edge E0 with in_valid&&in_ready: latch divisor=d, quo=f, rem=0 (n+1 bits), count=0.
  - If d!=0: go to CALC.
  - If d==0: go straight to DONE with q=all ones, r=f, div_zero=1.
  - in_valid without in_ready is ignored; the source must hold.
- CALC: one restoring step per clock.
  - {rem,quo} <= {rem,quo}<<1.
  - If shifted rem >= divisor: rem -= divisor and quo LSB=1; else LSB=0.
  - Compare and subtract are done at n+1 bits so no overflow occurs for d up to 2^n-1.
  - count increments each step. After step n (edge En, count==n-1 before the edge): go to DONE, q=quo, r=rem[n-1:0], div_zero=0.
- Latency: out_valid high after edge E0+n for nonzero d, after E0 for d==0.
- DONE:
  - q/r/div_zero held stable while out_valid && !out_ready.
  - On edge with out_ready=1: go to IDLE, clear out_valid. q/r keep their last values; don't-care once out_valid=0.
- Throughput: at most one operation per n+2 cycles. No accept in the same cycle as result hand-off (in_ready=0 in DONE).
- Simultaneous in_valid with out_ready in DONE: input not accepted until the next cycle in IDLE.
- Boundaries:
  - f=0 gives q=0, r=0.
  - f<d gives q=0, r=f.
  - d=1 gives q=f, r=0.
  - f and d at max (2^n-1) gives q=1, r=0.
- All arithmetic is unsigned; f and d are treated as unsigned n-bit, matching the wrap-around of the pipe.

Decomposition:
- Shared package:
  - state enum (IDLE, CALC, DONE);
  - default width constant N_W=10;
  - count width constant $clog2(N_W+1).
- One natural sub-module: pipe_div_step. Combinational single restoring step; inputs rem(n+1), quo(n), divisor(n); outputs next rem and quo. The top holds the FSM, registers and handshake.

Test Plan:
- Pipe vector a=2,b=3,c=9,d=5 gives f=45. Drive f=45,d=5 → after 10 cycles q=9, r=0, div_zero=0, out_valid=1.
- f=1000,d=3 → q=333, r=1. Also f=7,d=10 → q=0, r=7. Also f=1023,d=1 → q=1023, r=0.
- f=17,d=0 → out_valid on the cycle after acceptance, q=1023, r=17, div_zero=1. No CALC cycles occur.
- Backpressure: complete f=50,d=5, then hold out_ready=0 for 5 cycles. q=10, r=0 stay stable, in_ready stays 0. Raise out_ready → IDLE and in_ready=1 the next cycle.
- Reset mid-op: accept f=900,d=7, pull rst_n low at CALC step 4 → out_valid=0, in_ready=1 after release, no stale result. A new f=900,d=7 → q=128, r=4.
- Back-to-back: keep in_valid high with 4 operand pairs and out_ready=1 → each result appears exactly once, in order, spaced n+2 cycles apart.
